// File: rtl/hexbox_pkg.sv
// Shared definitions for the hexbox overlay: box geometry, scan coordinate types and FSM encodings.
package hexbox_pkg;

  localparam int HEXBOX_W      = 64;
  localparam int HEXBOX_H      = 16;
  localparam int HEXBOX_DIGITS = 8;
  localparam int DIGIT_W       = 8;
  localparam int DIGIT_H       = 16;

  typedef logic [5:0] hexbox_x_t;
  typedef logic [3:0] hexbox_y_t;

  // Window FSM: idle until the first frame_start, then scan forever.
  localparam logic [0:0] ST_WAIT_FRAME = 1'b0;
  localparam logic [0:0] ST_RUN        = 1'b1;

endpackage

// File: rtl/video_pos_counter.sv
// Tracks the active-pixel column/row from de/line_start/frame_start, with saturating counters.
module video_pos_counter #(
  parameter int POS_W = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             de,
  input  logic             line_start,
  input  logic             frame_start,
  output logic [POS_W-1:0] cur_col,
  output logic [POS_W-1:0] cur_row
);

  localparam logic [POS_W-1:0] POS_MAX = '1;

  logic [POS_W-1:0] col_cnt;
  logic [POS_W-1:0] row_cnt;
  logic             ls_q;
  logic             fs_q;

  assign ls_q = de & line_start;
  assign fs_q = de & frame_start;

  always_comb begin
    cur_col = ls_q ? '0 : col_cnt;
    if (fs_q) begin
      cur_row = '0;
    end else if (ls_q) begin
      cur_row = (row_cnt == POS_MAX) ? POS_MAX : row_cnt + 1'b1;
    end else begin
      cur_row = row_cnt;
    end
  end

  // Saturation keeps over-long lines parked outside any window instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (de) begin
      col_cnt <= (cur_col == POS_MAX) ? POS_MAX : cur_col + 1'b1;
      row_cnt <= cur_row;
    end
  end

endmodule

// File: rtl/hexbox_window.sv
// Maps the active-pixel stream onto hexbox scan coordinates for a box at (WIN_X, WIN_Y),
// scaled by 2^SCALE_LOG2, and holds the displayed value stable across each frame.
module hexbox_window
  import hexbox_pkg::*;
#(
  parameter int WIN_X      = 16,
  parameter int WIN_Y      = 16,
  parameter int SCALE_LOG2 = 0,
  parameter int POS_W      = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        de,
  input  logic        line_start,
  input  logic        frame_start,
  input  logic [31:0] value_in,
  input  logic        value_valid,
  output logic        enable,
  output hexbox_x_t   x,
  output hexbox_y_t   y,
  output logic [31:0] value
);

  localparam int X_END = WIN_X + (HEXBOX_W << SCALE_LOG2);
  localparam int Y_END = WIN_Y + (HEXBOX_H << SCALE_LOG2);

  // Compares run one bit wider so a box touching the top of the counter range stays exact.
  localparam logic [POS_W:0]   X_LO  = (POS_W+1)'(WIN_X);
  localparam logic [POS_W:0]   X_HI  = (POS_W+1)'(X_END);
  localparam logic [POS_W:0]   Y_LO  = (POS_W+1)'(WIN_Y);
  localparam logic [POS_W:0]   Y_HI  = (POS_W+1)'(Y_END);
  localparam logic [POS_W-1:0] X_OFF = POS_W'(WIN_X);
  localparam logic [POS_W-1:0] Y_OFF = POS_W'(WIN_Y);

  logic [0:0]       state;
  logic [POS_W-1:0] cur_col;
  logic [POS_W-1:0] cur_row;
  logic [POS_W:0]   col_ext;
  logic [POS_W:0]   row_ext;
  logic [POS_W-1:0] dx;
  logic [POS_W-1:0] dy;
  logic             starting;
  logic             active;
  logic             in_x;
  logic             in_y;
  logic             hit;
  hexbox_x_t        x_next;
  hexbox_y_t        y_next;
  logic [31:0]      pending;

  video_pos_counter #(
    .POS_W (POS_W)
  ) u_pos (
    .clk         (clk),
    .reset       (reset),
    .de          (de),
    .line_start  (line_start),
    .frame_start (frame_start),
    .cur_col     (cur_col),
    .cur_row     (cur_row)
  );

  always_comb begin
    starting = de & frame_start;
    active   = (state == ST_RUN) | starting;
    col_ext  = {1'b0, cur_col};
    row_ext  = {1'b0, cur_row};
    in_x     = (col_ext >= X_LO) && (col_ext < X_HI);
    in_y     = (row_ext >= Y_LO) && (row_ext < Y_HI);
    hit      = de & active & in_x & in_y;
    dx       = cur_col - X_OFF;
    dy       = cur_row - Y_OFF;
    x_next   = hexbox_x_t'(dx >> SCALE_LOG2);
    y_next   = hexbox_y_t'(dy >> SCALE_LOG2);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_WAIT_FRAME;
    end else if (starting) begin
      state <= ST_RUN;
    end
  end

  // Coordinates only move on in-box pixels; outside the box they keep their last value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable <= 1'b0;
      x      <= '0;
      y      <= '0;
    end else begin
      enable <= hit;
      if (hit) begin
        x <= x_next;
        y <= y_next;
      end
    end
  end

  // A value arriving on the frame_start pixel itself is shown immediately (bypass).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
      value   <= '0;
    end else begin
      if (value_valid) begin
        pending <= value_in;
      end
      if (starting) begin
        value <= value_valid ? value_in : pending;
      end
    end
  end

endmodule

// File: tb/tb_hexbox_window.sv
// Scoreboard bench for hexbox_window: two instances (16,16,S=0) and (0,0,S=1) share one pixel stream.
module tb_hexbox_window;

  logic        clk = 1'b0;
  logic        reset;
  logic        de;
  logic        line_start;
  logic        frame_start;
  logic [31:0] value_in;
  logic        value_valid;

  logic        ea, eb;
  logic [5:0]  xa, xb;
  logic [3:0]  ya, yb;
  logic [31:0] va, vb;

  int checks   = 0;
  int failures = 0;

  // Entries are {enable, x[5:0], y[3:0], value[31:0]}.
  logic [42:0] exp_a_q[$];
  logic [42:0] exp_b_q[$];

  bit          m_run;
  logic [31:0] m_pend;
  logic [31:0] m_disp;
  logic [9:0]  pa, pb;

  int          inj_row[2];
  int          inj_col[2];
  logic [31:0] inj_val[2];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  hexbox_window #(.WIN_X(16), .WIN_Y(16), .SCALE_LOG2(0), .POS_W(12)) dut_a (
    .clk (clk), .reset (reset), .de (de), .line_start (line_start),
    .frame_start (frame_start), .value_in (value_in), .value_valid (value_valid),
    .enable (ea), .x (xa), .y (ya), .value (va)
  );

  hexbox_window #(.WIN_X(0), .WIN_Y(0), .SCALE_LOG2(1), .POS_W(12)) dut_b (
    .clk (clk), .reset (reset), .de (de), .line_start (line_start),
    .frame_start (frame_start), .value_in (value_in), .value_valid (value_valid),
    .enable (eb), .x (xb), .y (yb), .value (vb)
  );

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  function automatic logic [10:0] exp_pos(input int wx, input int wy, input int s,
                                          input bit de_i, input bit run_i,
                                          input int col, input int row,
                                          input logic [9:0] prev);
    int cc;
    cc = (col > 4095) ? 4095 : col;
    if (de_i && run_i && cc >= wx && cc < wx + (64 << s) && row >= wy && row < wy + (16 << s))
      return {1'b1, 6'((cc - wx) >> s), 4'((row - wy) >> s)};
    return {1'b0, prev};
  endfunction

  always @(negedge clk) begin
    logic [42:0] e;
    if (exp_a_q.size() > 0) begin
      e = exp_a_q.pop_front();
      check("a_enable", 32'(ea), 32'(e[42]));
      check("a_x",      32'(xa), 32'(e[41:36]));
      check("a_y",      32'(ya), 32'(e[35:32]));
      check("a_value",  va,      e[31:0]);
    end
    if (exp_b_q.size() > 0) begin
      e = exp_b_q.pop_front();
      check("b_enable", 32'(eb), 32'(e[42]));
      check("b_x",      32'(xb), 32'(e[41:36]));
      check("b_y",      32'(yb), 32'(e[35:32]));
      check("b_value",  vb,      e[31:0]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic px(input bit de_i, input bit ls_i, input bit fs_i, input int col, input int row,
                    input bit vv_i = 1'b0, input logic [31:0] vin = '0);
    logic [10:0] ra, rb;
    @(negedge clk);
    de = de_i; line_start = ls_i; frame_start = fs_i;
    value_valid = vv_i; value_in = vin;
    if (de_i && fs_i) begin
      m_run  = 1'b1;
      m_disp = vv_i ? vin : m_pend;
    end
    if (vv_i) m_pend = vin;
    ra = exp_pos(16, 16, 0, de_i, m_run, col, row, pa);
    rb = exp_pos(0, 0, 1, de_i, m_run, col, row, pb);
    pa = ra[9:0];
    pb = rb[9:0];
    @(posedge clk);
    exp_a_q.push_back({ra[10], pa, m_disp});
    exp_b_q.push_back({rb[10], pb, m_disp});
  endtask

  task automatic drive_line(input int row, input int len, input bit fs,
                            input int gap_at = -1, input int blank = 4);
    bit          vv;
    logic [31:0] vin;
    for (int c = 0; c < len; c++) begin
      if (c == gap_at)
        for (int g = 0; g < 3; g++) px(1'b0, 1'b0, 1'b0, c, row);
      vv  = 1'b0;
      vin = '0;
      for (int k = 0; k < 2; k++)
        if (inj_row[k] == row && inj_col[k] == c) begin
          vv  = 1'b1;
          vin = inj_val[k];
        end
      px(1'b1, c == 0, fs && c == 0, c, row, vv, vin);
    end
    for (int b = 0; b < blank; b++) px(1'b0, 1'b0, 1'b0, 0, row);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_a_enable"}, 32'(ea), 32'd0);
    check({tag, "_a_x"},      32'(xa), 32'd0);
    check({tag, "_a_y"},      32'(ya), 32'd0);
    check({tag, "_a_value"},  va,      32'd0);
    check({tag, "_b_enable"}, 32'(eb), 32'd0);
    check({tag, "_b_x"},      32'(xb), 32'd0);
    check({tag, "_b_y"},      32'(yb), 32'd0);
    check({tag, "_b_value"},  vb,      32'd0);
  endtask

  task automatic clear_model();
    m_run = 1'b0; m_pend = '0; m_disp = '0; pa = '0; pb = '0;
    for (int k = 0; k < 2; k++) begin
      inj_row[k] = -1; inj_col[k] = -1; inj_val[k] = '0;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; de = 1'b0; line_start = 1'b0; frame_start = 1'b0;
    value_valid = 1'b0; value_in = '0;
    clear_model();
    #12;
    check_outputs_zero("por");
    @(negedge clk);
    reset = 1'b0;

    // No frame_start yet: line_starts are ignored, pending value loads but is not shown.
    for (int i = 0; i < 100; i++)
      px(1'b1, (i % 20) == 0, 1'b0, i % 20, 0, i == 50, 32'h0000_0055);
    for (int i = 0; i < 4; i++) px(1'b0, 1'b0, 1'b0, 0, 0);

    // Frame 1: 800-pixel lines, de gap inside the box on row 16, over-long row 20.
    inj_row[0] = 5;  inj_col[0] = 100; inj_val[0] = 32'h1111_1111;
    inj_row[1] = 10; inj_col[1] = 100; inj_val[1] = 32'habcd_1234;
    for (int r = 0; r < 34; r++)
      drive_line(r, (r == 20) ? 4200 : 800, r == 0, (r == 16) ? 40 : -1);

    // Frame 2 shows the last mid-frame value; row 2 is cut short by a new frame.
    inj_row[0] = -1; inj_row[1] = -1;
    drive_line(0, 100, 1'b1);
    drive_line(1, 100, 1'b0);
    drive_line(2, 50, 1'b0, -1, 0);

    // Frame 3: value_valid coincident with frame_start bypasses straight to the output.
    inj_row[0] = 0; inj_col[0] = 0; inj_val[0] = 32'h0000_0001;
    drive_line(0, 100, 1'b1);
    inj_row[0] = -1;
    drive_line(1, 20, 1'b0);
    for (int c = 0; c < 10; c++) px(1'b1, c == 0, 1'b0, c, 2);

    // Reset inside dut_b's box: outputs clear without a clock edge.
    @(negedge clk);
    de = 1'b0; line_start = 1'b0; frame_start = 1'b0; value_valid = 1'b0;
    check("pre_reset_b_enable", 32'(eb), 32'd1);
    #2 reset = 1'b1;
    #1 check_outputs_zero("midreset");
    clear_model();
    @(negedge clk);
    #2 reset = 1'b0;

    drive_line(3, 50, 1'b0);
    drive_line(0, 140, 1'b1);
    drive_line(1, 140, 1'b0);

    repeat (3) @(negedge clk);
    check("queue_a_drained", 32'(exp_a_q.size()), 32'd0);
    check("queue_b_drained", 32'(exp_b_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hexbox_window.md
Name: hexbox_window

Overview:
- Upstream feeder for hexbox: turns the video pipeline's active-pixel stream (de, line_start, frame_start) into hexbox's enable/x/y scan coordinates.
- Places a 64x16-pixel hex box (8 digits of 8x16) at a parameterised screen position, with optional integer pixel scaling.
- Holds the displayed 32-bit value stable per frame, so digits never tear mid-frame.

Parameters:
- WIN_X, 16, left screen column of the box (active-pixel units).
- WIN_Y, 16, top screen row of the box.
- SCALE_LOG2, 0, box scale = 2^SCALE_LOG2 (legal 0..2); box occupies 64<<S by 16<<S pixels.
- POS_W, 12, width of internal column/row counters.

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- de  in  1  active pixel this cycle
- line_start  in  1  pulse with the first de pixel of each line; qualified by de
- frame_start  in  1  pulse with the first de pixel of line 0; qualified by de; always coincident with line_start
- value_in  in  32  new value to display
- value_valid  in  1  value_in is valid this cycle
- enable  out  1  hexbox enable: current pixel is inside the box
- x  out  6  hexbox column 0..63
- y  out  4  hexbox row 0..15
- value  out  32  frame-stable value to hexbox

Behaviour:
- Reset (async, active-high):
  - enable=0, x=0, y=0, value=0.
  - Pending value=0, counters=0, FSM→WAIT_FRAME.
- FSM states:
  - WAIT_FRAME: outputs held at reset values except value; leaves on the first de&frame_start to RUN.
  - RUN: normal operation; stays in RUN until reset.
- Per-pixel position (combinational, only when de=1):
  - cur_col = line_start ? 0 : col_cnt.
  - cur_row = frame_start ? 0 : (line_start ? row_cnt+1 : row_cnt).
- Counter updates on each de cycle:
  - col_cnt <= cur_col+1, saturating at 2^POS_W-1.
  - row_cnt <= cur_row, saturating likewise.
  - de=0 leaves both counters unchanged.
- Hit test: hit = de & RUN-or-entering-RUN & (WIN_X <= cur_col < WIN_X+(64<<S)) & (WIN_Y <= cur_row < WIN_Y+(16<<S)).
- Outputs, registered, latency exactly 1 cycle from the de pixel:
  - enable <= hit.
  - x <= (cur_col-WIN_X)>>S, truncated to 6 bits.
  - y <= (cur_row-WIN_Y)>>S, truncated to 4 bits.
  - When hit=0: enable <= 0 and x/y hold their last values.
  - The first frame_start pixel is itself processed; if WIN_X=WIN_Y=0 it produces enable=1, x=0, y=0.
- Value handling:
  - value_valid loads pending <= value_in on any cycle, in any state.
  - On de&frame_start: value <= pending. If value_valid is high the same cycle, value <= value_in (bypass) and pending <= value_in.
  - value changes only at frame_start, never mid-frame.
  - Back-to-back value_valid pulses within a frame: last one wins.
- Boundary conditions:
  - line_start without frame_start before any frame_start: ignored (FSM still in WAIT_FRAME).
  - frame_start mid-line: treated as a new frame; counters restart.
  - Lines longer than 2^POS_W: col saturates and never aliases back into the window.
  - Reset mid-frame: outputs clear immediately; enable stays 0 until the next frame_start.
- No backpressure: one pixel per de cycle.

Decomposition:
- Shared package hexbox_pkg:
  - Constants: HEXBOX_W=64, HEXBOX_H=16, HEXBOX_DIGITS=8, DIGIT_W=8, DIGIT_H=16.
  - Typedefs: hexbox_x_t (6b), hexbox_y_t (4b).
  - hexbox consumes the same package.
- One natural sub-module: video_pos_counter. It holds col/row counters with saturation and the frame/line qualification, and is reusable by other overlay stages.
- Window compare, scaling, value latch and FSM stay in hexbox_window.

Test Plan:
- Reset, then de with no frame_start for 100 cycles → enable=0, x=0, y=0, value=0 throughout.
- WIN_X=16, WIN_Y=16, S=0, 800-pixel lines:
  - line 16, col 16 → next cycle enable=1, x=0, y=0.
  - col 79 → x=63.
  - col 80 → enable=0.
  - line 31, col 16 → y=15.
  - line 32 → enable never asserts.
- S=1, WIN_X=WIN_Y=0: cols 0,1 → x=0; col 2 → x=1; col 127 → x=63; col 128 → enable=0; rows 0..31 → y=row>>1.
- value_in=32'habcd1234 with value_valid mid-frame → value unchanged until next frame_start, then 32'habcd1234. value_valid with 32'h00000001 coincident with frame_start → value=32'h00000001 at that cycle+1.
- Assert reset mid-box (enable=1) → enable=0 asynchronously. Release, send line_start only → no enable. frame_start → scanning resumes from row 0.
- de gaps: de=0 for 3 cycles inside the box → x does not advance and enable=0 during the gap. After de resumes, x continues from the next column with no skipped or repeated column.
